// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - Wishbone N-master arbiter and slave-port multiplexer
//
// Purpose: grants one of MASTER_COUNT Wishbone masters access to a single
// slave port (round-robin or fixed priority), routes the granted master's
// request fields to the slave and steers ack/err back to that master only.
// Optional feature macro: WB_ARBITER_HOLD_LIMIT_EN (tenure beat limit).
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i         per-master cycle/strobe/write
//   m_adr_i/m_dat_i/m_sel_i        packed per-master address/write data/select
//   m_dat_o                        read data broadcast to all masters
//   m_ack_o/m_err_o                per-master acknowledge/error
//   s_cyc_o/s_stb_o/s_we_o         slave control
//   s_adr_o/s_dat_o/s_sel_o        slave address/write data/select
//   s_dat_i/s_ack_i/s_err_i        slave response
//   gnt_o                          index of current/last granted master

module wb_rr_arbiter #(
    parameter int MASTER_COUNT = 2,
    parameter int GNT_WIDTH    = $clog2(MASTER_COUNT),
    parameter int ADDR_WIDTH   = 24,
    parameter int DATA_WIDTH   = 8,
    parameter int SEL_WIDTH    = DATA_WIDTH / 8,
    parameter int ROUND_ROBIN  = 1,
    parameter int MAX_BEATS    = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [MASTER_COUNT-1:0]            m_cyc_i,
    input  logic [MASTER_COUNT-1:0]            m_stb_i,
    input  logic [MASTER_COUNT-1:0]            m_we_i,
    input  logic [MASTER_COUNT*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [MASTER_COUNT*DATA_WIDTH-1:0] m_dat_i,
    input  logic [MASTER_COUNT*SEL_WIDTH-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]              m_dat_o,
    output logic [MASTER_COUNT-1:0]            m_ack_o,
    output logic [MASTER_COUNT-1:0]            m_err_o,
    output logic                               s_cyc_o,
    output logic                               s_stb_o,
    output logic                               s_we_o,
    output logic [ADDR_WIDTH-1:0]              s_adr_o,
    output logic [DATA_WIDTH-1:0]              s_dat_o,
    output logic [SEL_WIDTH-1:0]               s_sel_o,
    input  logic [DATA_WIDTH-1:0]              s_dat_i,
    input  logic                               s_ack_i,
    input  logic                               s_err_i,
    output logic [GNT_WIDTH-1:0]               gnt_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [GNT_WIDTH-1:0]    gnt_q, gnt_d;
    logic [MASTER_COUNT-1:0] eligible;
    logic                    win_found;
    logic [GNT_WIDTH-1:0]    win_idx;
    int                      win_pos;
    logic                    owner_cyc;
    logic                    owner_stb;

`ifdef WB_ARBITER_HOLD_LIMIT_EN
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic                 mask_v_q, mask_v_d;
    logic [GNT_WIDTH-1:0] mask_idx_q, mask_idx_d;
    logic                 beat;
    logic                 others;
    logic                 limit_hit;
`endif

    assign s_cyc_o = (state_q == ST_BUSY);
    assign gnt_o   = gnt_q;
    assign m_dat_o = s_dat_i;

    // Requesters allowed to compete in this arbitration. Under fixed priority
    // a just-preempted master sits out exactly one arbitration.
    always_comb begin
        eligible = m_cyc_i;
`ifdef WB_ARBITER_HOLD_LIMIT_EN
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if (mask_v_q && (mask_idx_q == GNT_WIDTH'(i))) begin
                eligible[i] = 1'b0;
            end
        end
`endif
    end

    // Winner search. Round-robin starts one past the last grant and checks
    // the last grant itself last; fixed priority takes the lowest index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = gnt_q;
        win_pos   = 0;
        for (int k = 0; k < MASTER_COUNT; k++) begin
            if (ROUND_ROBIN != 0) begin
                win_pos = (int'(gnt_q) + 1 + k) % MASTER_COUNT;
            end else begin
                win_pos = k;
            end
            if (!win_found && eligible[win_pos]) begin
                win_found = 1'b1;
                win_idx   = GNT_WIDTH'(win_pos);
            end
        end
    end

    // Request mux and response steering; an index matching no master
    // leaves everything at zero.
    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        m_ack_o   = '0;
        m_err_o   = '0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if (gnt_q == GNT_WIDTH'(i)) begin
                s_adr_o    = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o    = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                s_sel_o    = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
                s_we_o     = m_we_i[i];
                owner_cyc  = m_cyc_i[i];
                owner_stb  = m_stb_i[i];
                m_ack_o[i] = s_ack_i & s_cyc_o;
                m_err_o[i] = s_err_i & s_cyc_o;
            end
        end
    end

    assign s_stb_o = s_cyc_o & owner_stb;

`ifdef WB_ARBITER_HOLD_LIMIT_EN
    always_comb begin
        beat   = s_ack_i | s_err_i;
        others = 1'b0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if ((gnt_q != GNT_WIDTH'(i)) && m_cyc_i[i]) begin
                others = 1'b1;
            end
        end
        // This beat brings (or keeps) the saturating count at the limit.
        limit_hit = beat && (int'(beat_q) >= MAX_BEATS - 1);
    end
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
`ifdef WB_ARBITER_HOLD_LIMIT_EN
        beat_d     = beat_q;
        mask_v_d   = mask_v_q;
        mask_idx_d = mask_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef WB_ARBITER_HOLD_LIMIT_EN
                mask_v_d = 1'b0;
`endif
                if (win_found) begin
                    state_d = ST_BUSY;
                    gnt_d   = win_idx;
`ifdef WB_ARBITER_HOLD_LIMIT_EN
                    beat_d  = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (!owner_cyc) begin
                    state_d = ST_IDLE;
                end
`ifdef WB_ARBITER_HOLD_LIMIT_EN
                else if (beat) begin
                    if (int'(beat_q) < MAX_BEATS) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                    if (limit_hit && others) begin
                        state_d = ST_IDLE;
                        if (ROUND_ROBIN == 0) begin
                            mask_v_d   = 1'b1;
                            mask_idx_d = gnt_q;
                        end
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gnt_q      <= GNT_WIDTH'(MASTER_COUNT - 1);
`ifdef WB_ARBITER_HOLD_LIMIT_EN
            beat_q     <= '0;
            mask_v_q   <= 1'b0;
            mask_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
`ifdef WB_ARBITER_HOLD_LIMIT_EN
            beat_q     <= beat_d;
            mask_v_q   <= mask_v_d;
            mask_idx_q <= mask_idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - self-checking bench for wb_rr_arbiter
module tb_wb_rr_arbiter;

    localparam int MAXB = 4;
`ifdef WB_ARBITER_HOLD_LIMIT_EN
    localparam int EXP_DROP = 4;
    localparam int EXP_NEXT = 1;
`else
    localparam int EXP_DROP = 0;
    localparam int EXP_NEXT = 0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  cyc  [2];
    logic [3:0]  stb  [2];
    logic [3:0]  we   [2];
    logic [95:0] adr  [2];
    logic [31:0] dat  [2];
    logic [3:0]  sel  [2];
    logic [7:0]  sdat [2];
    logic        sack [2];
    logic        serr [2];

    logic [7:0]  mdat [2];
    logic [3:0]  mack [2];
    logic [3:0]  merr [2];
    logic        scyc [2];
    logic        sstb [2];
    logic        swe  [2];
    logic [23:0] sadr [2];
    logic [7:0]  sdo  [2];
    logic [0:0]  ssel [2];
    logic [1:0]  gnt  [2];

    // reference model: instance 0 round-robin, instance 1 fixed priority
    bit mbusy [2];
    int mown  [2];
    int mbeat [2];
    int mmask [2];

    int checks = 0;
    int errors = 0;
    int drop;
    int g5;

    wb_rr_arbiter #(.MASTER_COUNT(4), .ROUND_ROBIN(1), .MAX_BEATS(MAXB)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(cyc[0]), .m_stb_i(stb[0]), .m_we_i(we[0]),
        .m_adr_i(adr[0]), .m_dat_i(dat[0]), .m_sel_i(sel[0]),
        .m_dat_o(mdat[0]), .m_ack_o(mack[0]), .m_err_o(merr[0]),
        .s_cyc_o(scyc[0]), .s_stb_o(sstb[0]), .s_we_o(swe[0]),
        .s_adr_o(sadr[0]), .s_dat_o(sdo[0]), .s_sel_o(ssel[0]),
        .s_dat_i(sdat[0]), .s_ack_i(sack[0]), .s_err_i(serr[0]),
        .gnt_o(gnt[0])
    );

    wb_rr_arbiter #(.MASTER_COUNT(4), .ROUND_ROBIN(0), .MAX_BEATS(MAXB)) u_fp (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(cyc[1]), .m_stb_i(stb[1]), .m_we_i(we[1]),
        .m_adr_i(adr[1]), .m_dat_i(dat[1]), .m_sel_i(sel[1]),
        .m_dat_o(mdat[1]), .m_ack_o(mack[1]), .m_err_o(merr[1]),
        .s_cyc_o(scyc[1]), .s_stb_o(sstb[1]), .s_we_o(swe[1]),
        .s_adr_o(sadr[1]), .s_dat_o(sdo[1]), .s_sel_o(ssel[1]),
        .s_dat_i(sdat[1]), .s_ack_i(sack[1]), .s_err_i(serr[1]),
        .gnt_o(gnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step(input int k);
        int win;
        int c;
        if (rst) begin
            mbusy[k] = 0; mown[k] = 3; mbeat[k] = 0; mmask[k] = -1;
        end else if (!mbusy[k]) begin
            win = -1;
            for (int j = 0; j < 4; j++) begin
                c = (k == 0) ? (mown[k] + 1 + j) % 4 : j;
                if (win < 0 && cyc[k][c] && c != mmask[k]) win = c;
            end
            mmask[k] = -1;
            if (win >= 0) begin
                mbusy[k] = 1; mown[k] = win; mbeat[k] = 0;
            end
        end else if (!cyc[k][mown[k]]) begin
            mbusy[k] = 0;
        end
`ifdef WB_ARBITER_HOLD_LIMIT_EN
        else if (sack[k] || serr[k]) begin
            if (mbeat[k] < MAXB) mbeat[k]++;
            if (mbeat[k] >= MAXB && (cyc[k] & ~(4'b0001 << mown[k])) != 4'b0000) begin
                mbusy[k] = 0;
                if (k == 1) mmask[k] = mown[k];
            end
        end
`endif
    endtask

    task automatic model_check(input int k);
        logic [3:0] exp_resp;
        exp_resp = 4'b0001 << mown[k];
        chk(32'(scyc[k]), 32'(mbusy[k]), $sformatf("u%0d_s_cyc", k));
        chk(32'(gnt[k]), 32'(mown[k]), $sformatf("u%0d_gnt", k));
        chk(32'(sstb[k]), 32'(mbusy[k] && stb[k][mown[k]]), $sformatf("u%0d_s_stb", k));
        chk(32'(mack[k]), 32'((sack[k] && mbusy[k]) ? exp_resp : 4'b0000), $sformatf("u%0d_m_ack", k));
        chk(32'(merr[k]), 32'((serr[k] && mbusy[k]) ? exp_resp : 4'b0000), $sformatf("u%0d_m_err", k));
        chk(32'(sadr[k]), 32'(adr[k][mown[k]*24 +: 24]), $sformatf("u%0d_s_adr", k));
        chk(32'(swe[k]), 32'(we[k][mown[k]]), $sformatf("u%0d_s_we", k));
        chk(32'(sdo[k]), 32'(dat[k][mown[k]*8 +: 8]), $sformatf("u%0d_s_dat", k));
        chk(32'(ssel[k]), 32'(sel[k][mown[k]]), $sformatf("u%0d_s_sel", k));
        chk(32'(mdat[k]), 32'(sdat[k]), $sformatf("u%0d_m_dat", k));
    endtask

    task automatic cycle();
        #1;
        model_check(0);
        model_check(1);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc[k] = '0; stb[k] = '0; we[k] = '0; adr[k] = '0; dat[k] = '0;
            sel[k] = '0; sdat[k] = '0; sack[k] = 1'b0; serr[k] = 1'b0;
        end
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cycle();
        chk(32'(scyc[0]), 32'd0, "rst_s_cyc");
        chk(32'(gnt[0]), 32'd3, "rst_gnt");
        chk(32'(mack[1]), 32'd0, "rst_m_ack");
        rst = 1'b0;

        // round-robin: all four request, one beat each
        cyc[0] = 4'hF; stb[0] = 4'hF;
        for (int t = 0; t < 5; t++) begin
            cycle();
            chk(32'(scyc[0]), 32'd1, "rr_grant_cyc");
            chk(32'(gnt[0]), 32'(t % 4), "rr_grant_idx");
            sack[0] = 1'b1;
            #1;
            chk(32'(mack[0]), 32'(4'b0001 << (t % 4)), "rr_ack_route");
            cycle();
            sack[0] = 1'b0;
            cyc[0][t % 4] = 1'b0;
            cycle();
            chk(32'(scyc[0]), 32'd0, "rr_release_idle");
            cyc[0][t % 4] = 1'b1;
        end
        cyc[0] = '0; stb[0] = '0;
        cycle();

        // fixed priority: master 1 re-requests during the idle cycle, 3 starves
        cyc[1] = 4'b1010; stb[1] = 4'b1010;
        cycle();
        chk(32'(gnt[1]), 32'd1, "fp_first_grant");
        cyc[1] = 4'b1000;
        cycle();
        chk(32'(scyc[1]), 32'd0, "fp_release");
        cyc[1] = 4'b1010;
        cycle();
        chk(32'(gnt[1]), 32'd1, "fp_regrant");
        cycle();
        chk(32'(gnt[1]), 32'd1, "fp_starve");
        cyc[1] = '0; stb[1] = '0;
        cycle();

        // muxing and response steering on master 1
        cyc[0] = 4'b0010; stb[0] = 4'b0010; we[0] = 4'b0010; sel[0] = 4'b0010;
        adr[0] = '0; adr[0][24 +: 24] = 24'h00ABCD; dat[0][8 +: 8] = 8'h5A;
        cycle();
        chk(32'(gnt[0]), 32'd1, "mux_gnt");
        chk(32'(sadr[0]), 32'h00ABCD, "mux_adr");
        chk(32'(swe[0]), 32'd1, "mux_we");
        chk(32'(sdo[0]), 32'h5A, "mux_dat");
        sack[0] = 1'b1;
        #1;
        chk(32'(mack[0]), 32'b0010, "mux_ack");
        chk(32'(merr[0]), 32'b0000, "mux_ack_noerr");
        sack[0] = 1'b0; serr[0] = 1'b1;
        #1;
        chk(32'(merr[0]), 32'b0010, "mux_err");
        chk(32'(mack[0]), 32'b0000, "mux_err_noack");
        serr[0] = 1'b0; cyc[0] = '0;
        cycle();
        sack[0] = 1'b1;
        #1;
        chk(32'(mack[0]), 32'd0, "idle_ack_ignored");
        sack[0] = 1'b0;

        // tenure limit: master 0 streams while master 1 waits
        cyc[0] = 4'b0011; stb[0] = 4'b0011;
        cycle();
        chk(32'(gnt[0]), 32'd0, "hold_first_grant");
        sack[0] = 1'b1; drop = 0; g5 = -1;
        for (int n = 1; n <= 8; n++) begin
            cycle();
            if (drop == 0 && scyc[0] == 1'b0) drop = n;
            if (n == 5) g5 = int'(gnt[0]);
        end
        chk(32'(drop), 32'(EXP_DROP), "hold_drop_beat");
        chk(32'(g5), 32'(EXP_NEXT), "hold_next_gnt");
        sack[0] = 1'b0; cyc[0] = '0;
        cycle();
        cycle();
        cyc[0] = 4'b0001; stb[0] = 4'b0001;
        cycle();
        sack[0] = 1'b1; drop = 0;
        for (int n = 1; n <= 8; n++) begin
            cycle();
            if (drop == 0 && scyc[0] == 1'b0) drop = n;
        end
        chk(32'(drop), 32'd0, "hold_alone_no_drop");
        sack[0] = 1'b0; cyc[0] = '0;
        cycle();

        // reset while busy with strobe high
        cyc[0] = 4'b0001; stb[0] = 4'b0001; cyc[1] = 4'b0100; stb[1] = 4'b0100;
        cycle();
        chk(32'(scyc[0]), 32'd1, "pre_rst_busy0");
        chk(32'(scyc[1]), 32'd1, "pre_rst_busy1");
        rst = 1'b1;
        cycle();
        chk(32'(scyc[0]), 32'd0, "rst_busy_cyc");
        chk(32'(sstb[0]), 32'd0, "rst_busy_stb");
        chk(32'(gnt[0]), 32'd3, "rst_busy_gnt");
        chk(32'(scyc[1]), 32'd0, "rst_busy_cyc_fp");
        chk(32'(gnt[1]), 32'd3, "rst_busy_gnt_fp");
        rst = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 2; k++) begin
                cyc[k]  = cyc[k] ^ 4'($urandom & $urandom & $urandom);
                stb[k]  = 4'($urandom);
                we[k]   = 4'($urandom);
                adr[k]  = {$urandom, $urandom, $urandom};
                dat[k]  = $urandom;
                sel[k]  = 4'($urandom);
                sdat[k] = 8'($urandom);
                sack[k] = ($urandom_range(0, 1) == 1);
                serr[k] = ($urandom_range(0, 7) == 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Parametrised Wishbone (classic, single-cycle-registered grant) arbiter and bus multiplexer for N masters sharing one slave port. Selects a master by round-robin or fixed priority, routes its address/data/control to the slave, and steers ack/err back to the granted master only. Optionally limits a master's tenure to a maximum beat count when others are waiting. Sits between the design's Wishbone masters and the shared memory/peripheral interconnect.

## Interface
- MASTER_COUNT, 2, number of masters (>=2)
- GNT_WIDTH, $clog2(MASTER_COUNT), grant index width
- ADDR_WIDTH, 24, address width
- DATA_WIDTH, 8, data width
- SEL_WIDTH, DATA_WIDTH/8, byte-select width
- ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
- MAX_BEATS, 16, tenure beat limit (>=1; used only with WB_ARBITER_HOLD_LIMIT_EN)

- clk_i  in  1  clock, single clock domain
- rst_i  in  1  synchronous active-high reset
- m_cyc_i / m_stb_i / m_we_i  in  MASTER_COUNT each  per-master cycle/strobe/write
- m_adr_i  in  MASTER_COUNT*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_dat_i  in  MASTER_COUNT*DATA_WIDTH  packed write data
- m_sel_i  in  MASTER_COUNT*SEL_WIDTH  packed byte selects
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- m_ack_o / m_err_o  out  MASTER_COUNT  per-master ack/err
- s_cyc_o / s_stb_o / s_we_o  out  1  slave control
- s_adr_o / s_dat_o / s_sel_o  out  ADDR_WIDTH / DATA_WIDTH / SEL_WIDTH  slave address/data/select
- s_dat_i  in  DATA_WIDTH;  s_ack_i / s_err_i  in  1  slave response
- gnt_o  out  GNT_WIDTH  index of current/last granted master

## Operation
- States: IDLE (s_cyc_o=0), BUSY (s_cyc_o=1). s_cyc_o and gnt_o are registered.
- IDLE: if any eligible m_cyc_i, load winner into gnt_o, go BUSY. None: stay IDLE, gnt_o holds.
- Round-robin: search starts at gnt_o+1, wraps modulo MASTER_COUNT; gnt_o itself is checked last.
- Fixed priority: lowest asserted index wins.
- BUSY: if m_cyc_i[gnt_o]=0, go IDLE. Always at least one IDLE cycle between tenures.
- Mux (combinational): s_adr_o/s_dat_o/s_sel_o/s_we_o = granted master's fields; s_stb_o = s_cyc_o & m_stb_i[gnt_o].
- m_ack_o[i] = s_ack_i & s_cyc_o & (gnt_o==i); same for m_err_o. m_dat_o = s_dat_i.
- Non-granted masters see no ack/err and stall with cyc/stb held.
- Slave response while s_cyc_o=0: ignored, not forwarded.
- gnt_o >= MASTER_COUNT is never produced; out-of-range index in mux drives zeros.

## Timing
- Reset: s_cyc_o=0, gnt_o=MASTER_COUNT-1 (first round-robin search starts at 0), beat counter=0, state IDLE; derived outputs s_stb_o=0, m_ack_o=0, m_err_o=0.
- Grant latency: m_cyc_i sampled high at edge N (in IDLE) -> s_cyc_o=1, gnt_o valid after edge N.
- Release latency: m_cyc_i[gnt_o] sampled low at edge N -> s_cyc_o=0 after edge N; next grant earliest after edge N+1.
- Ack pass-through is combinational, zero added latency.
- Reset mid-tenure: s_cyc_o drops after the reset edge; any in-flight transfer is abandoned.

## Configuration
- WB_ARBITER_HOLD_LIMIT_EN defined: a beat counter counts ack|err cycles in BUSY, cleared on entry to BUSY. When a beat completes with count reaching MAX_BEATS and any other m_cyc_i is high, go IDLE (preemption). Round-robin: the preempted master ends up lowest priority naturally. Fixed priority: the preempted master is masked for the next arbitration only. Count reaching MAX_BEATS with no other requester: saturate, no preemption; preempt on the first later beat where another requester is present.
- Undefined: no counter; a tenure ends only when the master drops cyc; MAX_BEATS is ignored.

## Test plan
- Reset, then m_cyc_i=2'b01 held: s_cyc_o=1 and gnt_o=0 one cycle after; m_ack_o=2'b01 on each s_ack_i; drop cyc -> s_cyc_o=0 next cycle.
- ROUND_ROBIN=1, MASTER_COUNT=4, all four request, each releases after 1 beat: grants 0,1,2,3,0, one idle cycle between tenures.
- ROUND_ROBIN=0, masters 1 and 3 requesting, master 1 releases and re-requests during the idle cycle: master 1 is granted again and master 3 starves.
- Muxing: master 1 granted with adr=24'h00ABCD, we=1, sel=1: s_adr_o=24'h00ABCD, s_we_o=1; s_ack_i pulse -> m_ack_o=2'b10 only; s_err_i pulse -> m_err_o=2'b10 only.
- WB_ARBITER_HOLD_LIMIT_EN, MAX_BEATS=4, master 0 streaming with master 1 waiting: s_cyc_o drops after the 4th ack, master 1 granted next. Repeat without master 1: no drop after 8 acks.
- rst_i asserted while BUSY with stb high: s_cyc_o=0 and s_stb_o=0 after the edge; gnt_o=MASTER_COUNT-1.
